// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one sha256XMSS core between NUM_REQ requesters,
// with a grant lock that keeps store/continue-intermediate sequences atomic.
module hash_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 1024,
  parameter int KEY_LEN = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]        req_message_length,
  input  logic [NUM_REQ-1:0]        req_store_intermediate,
  input  logic [NUM_REQ-1:0]        req_continue_intermediate,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [KEY_LEN-1:0]        req_data_out,
  output logic                      hash_start,
  output logic [DATA_W-1:0]         hash_data_in,
  output logic                      hash_message_length,
  output logic                      hash_store_intermediate,
  output logic                      hash_continue_intermediate,
  input  logic [KEY_LEN-1:0]        hash_data_out,
  input  logic                      hash_done,
  output logic                      busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                          state, state_nxt;
  logic [NUM_REQ-1:0]              pending, grant, elig;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_v;
  logic [IDX_W-1:0]                g_idx, last_grant, lock_owner, pick_idx, rr_idx;
  logic                            lock, pick_vld, load, done_fire;

  assign data_v = req_data_in;

  // Round-robin from last_grant+1; the lowest offset that is eligible wins.
  always_comb begin
    elig     = lock ? (pending & (NUM_REQ'(1) << lock_owner)) : pending;
    pick_vld = 1'b0;
    pick_idx = last_grant;
    rr_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (elig[rr_idx]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_fire = 1'b0;
    case (state)
      IDLE:  if (pick_vld) begin state_nxt = ISSUE; load = 1'b1; end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (hash_done) begin state_nxt = IDLE; done_fire = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand mux is AND-OR over the registered one-hot grant, so no grant gives 0.
  always_comb begin
    hash_data_in               = '0;
    hash_message_length        = 1'b0;
    hash_store_intermediate    = 1'b0;
    hash_continue_intermediate = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        hash_data_in               = hash_data_in | data_v[i];
        hash_message_length        = hash_message_length | req_message_length[i];
        hash_store_intermediate    = hash_store_intermediate | req_store_intermediate[i];
        hash_continue_intermediate = hash_continue_intermediate | req_continue_intermediate[i];
      end
    end
  end

  assign req_grant    = grant;
  assign req_done     = done_fire ? grant : '0;
  assign hash_start   = (state == ISSUE);
  assign req_data_out = hash_data_out;
  assign busy         = (state != IDLE) || (|pending);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= '0;
      grant      <= '0;
      g_idx      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      lock       <= 1'b0;
      lock_owner <= '0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~req_done) | req_start;
      if (load) begin
        grant <= NUM_REQ'(1) << pick_idx;
        g_idx <= pick_idx;
      end else if (done_fire) begin
        grant <= '0;
      end
      if (done_fire) begin
        last_grant <= g_idx;
        if (hash_store_intermediate) begin
          lock       <= 1'b1;
          lock_owner <= g_idx;
        end else if (lock && lock_owner == g_idx) begin
          lock <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter: table of request rounds plus hand-written
// lock, re-request, reset and spurious-done sequences. The bench models the core.
module tb_hash_arbiter;
  localparam int NR = 3, DW = 1024, KL = 256;

  logic             clk = 1'b0, reset;
  logic [NR-1:0]    req_start, req_ml, req_st, req_ct, req_grant, req_done;
  logic [NR*DW-1:0] req_data_in;
  logic [KL-1:0]    req_data_out, hash_data_out;
  logic [DW-1:0]    hash_data_in;
  logic             hash_start, hash_ml, hash_st, hash_ct, hash_done, busy;

  int n_chk = 0, n_fail = 0, n;

  typedef struct {
    logic [NR-1:0]      start;
    int                 cnt;
    logic [2:0][1:0]    ord;
  } vec_t;
  vec_t tbl[7];

  hash_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .KEY_LEN(KL)) dut (
    .clk(clk), .reset(reset), .req_start(req_start), .req_data_in(req_data_in),
    .req_message_length(req_ml), .req_store_intermediate(req_st),
    .req_continue_intermediate(req_ct), .req_grant(req_grant), .req_done(req_done),
    .req_data_out(req_data_out), .hash_start(hash_start), .hash_data_in(hash_data_in),
    .hash_message_length(hash_ml), .hash_store_intermediate(hash_st),
    .hash_continue_intermediate(hash_ct), .hash_data_out(hash_data_out),
    .hash_done(hash_done), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] opnd(input int i);
    return {128{8'hA5 ^ 8'(i)}};
  endfunction

  function automatic logic [KL-1:0] res(input int i);
    return {8{32'hC0DE0000 | 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ..%0h want ..%0h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  // Wait for launch, check operands, act as the core, complete after 10 cycles.
  task automatic serve(input int idx, input bit st, input bit ct, input bit again, output int waited);
    waited = 0;
    while (hash_start !== 1'b1 && waited < 20) begin tick(); waited++; end
    chk("launch", 64'(hash_start), 64'd1);
    chk("grant", 64'(req_grant), 64'(1) << idx);
    chkw("hash_data_in", hash_data_in, opnd(idx));
    chk("hash_store", 64'(hash_st), 64'(st));
    chk("hash_cont", 64'(hash_ct), 64'(ct));
    tick();
    chk("start_pulse_len", 64'(hash_start), 64'd0);
    repeat (9) tick();
    chk("no_early_done", 64'(req_done), 64'd0);
    hash_done     = 1'b1;
    hash_data_out = res(idx);
    if (again) req_start = NR'(1) << idx;
    #1;
    chk("req_done", 64'(req_done), 64'(1) << idx);
    chkw("req_data_out", DW'(req_data_out), DW'(res(idx)));
    tick();
    hash_done     = 1'b0;
    hash_data_out = '0;
    req_start     = '0;
  endtask

  initial begin
    reset = 1'b0; req_start = '0; req_ml = '0; req_st = '0; req_ct = '0;
    hash_done = 1'b0; hash_data_out = '0;
    for (int i = 0; i < NR; i++) req_data_in[i*DW +: DW] = opnd(i);
    req_ml = 3'b010;

    tbl[0] = '{start: 3'b100, cnt: 1, ord: {2'd0, 2'd0, 2'd2}};
    tbl[1] = '{start: 3'b111, cnt: 3, ord: {2'd2, 2'd1, 2'd0}};
    tbl[2] = '{start: 3'b111, cnt: 3, ord: {2'd2, 2'd1, 2'd0}};
    tbl[3] = '{start: 3'b101, cnt: 2, ord: {2'd0, 2'd2, 2'd0}};
    tbl[4] = '{start: 3'b110, cnt: 2, ord: {2'd0, 2'd2, 2'd1}};
    tbl[5] = '{start: 3'b011, cnt: 2, ord: {2'd0, 2'd1, 2'd0}};
    tbl[6] = '{start: 3'b111, cnt: 3, ord: {2'd1, 2'd0, 2'd2}};

    repeat (2) tick();
    chk("rst_grant", 64'(req_grant), 64'd0);
    chk("rst_done", 64'(req_done), 64'd0);
    chk("rst_hash_start", 64'(hash_start), 64'd0);
    chkw("rst_hash_data", hash_data_in, '0);
    chk("rst_flags", 64'({hash_ml, hash_st, hash_ct}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick();

    // Single request on requester 1: 2-cycle start latency.
    req_start = 3'b010;
    tick();
    req_start = '0;
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_no_start_yet", 64'(hash_start), 64'd0);
    chk("single_no_grant_yet", 64'(req_grant), 64'd0);
    serve(1, 0, 0, 0, n);
    chk("single_latency", 64'(n), 64'd1);
    chk("single_busy_clear", 64'(busy), 64'd0);

    for (int t = 0; t < 7; t++) begin
      req_start = tbl[t].start;
      tick();
      req_start = '0;
      for (int j = 0; j < tbl[t].cnt; j++) begin
        serve(int'(tbl[t].ord[j]), 0, 0, 0, n);
        chk("rr_dead_cycles", 64'(n), 64'd1);
      end
      chk("rr_busy_clear", 64'(busy), 64'd0);
    end

    // Lock: requester 1 stores intermediate while requester 0 is pending.
    req_st = 3'b010;
    req_start = 3'b010;
    tick();
    req_start = 3'b001;
    tick();
    req_start = '0;
    serve(1, 1, 0, 0, n);
    repeat (4) begin
      tick();
      chk("lock_hold_start", 64'(hash_start), 64'd0);
    end
    chk("lock_hold_grant", 64'(req_grant), 64'd0);
    chk("lock_hold_busy", 64'(busy), 64'd1);
    req_st = 3'b000;
    req_ct = 3'b010;
    req_start = 3'b010;
    tick();
    req_start = '0;
    serve(1, 0, 1, 0, n);
    chk("lock_owner_latency", 64'(n), 64'd1);
    req_ct = 3'b000;
    serve(0, 0, 0, 0, n);
    chk("lock_release_latency", 64'(n), 64'd1);
    chk("lock_busy_clear", 64'(busy), 64'd0);

    // Re-request in the same cycle as req_done.
    req_start = 3'b100;
    tick();
    req_start = '0;
    serve(2, 0, 0, 1, n);
    chk("rereq_busy", 64'(busy), 64'd1);
    serve(2, 0, 0, 0, n);
    chk("rereq_latency", 64'(n), 64'd1);
    chk("rereq_busy_clear", 64'(busy), 64'd0);

    // Reset during WAIT with a second request pending.
    req_start = 3'b011;
    tick();
    req_start = '0;
    n = 0;
    while (hash_start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rst_test_launch", 64'(hash_start), 64'd1);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(req_grant), 64'd0);
    chk("mid_rst_hash_start", 64'(hash_start), 64'd0);
    chkw("mid_rst_hash_data", hash_data_in, '0);
    chk("mid_rst_flags", 64'({hash_ml, hash_st, hash_ct}), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    req_start = 3'b001;
    tick();
    req_start = '0;
    serve(0, 0, 0, 0, n);
    chk("post_rst_latency", 64'(n), 64'd1);
    chk("post_rst_busy_clear", 64'(busy), 64'd0);

    // A repeated start while pending is absorbed.
    req_start = 3'b001;
    tick();
    tick();
    req_start = '0;
    serve(0, 0, 0, 0, n);
    chk("absorb_busy_clear", 64'(busy), 64'd0);

    // Spurious hash_done in IDLE.
    hash_done = 1'b1;
    #1;
    chk("spur_done", 64'(req_done), 64'd0);
    tick();
    hash_done = 1'b0;
    chk("spur_hash_start", 64'(hash_start), 64'd0);
    chk("spur_grant", 64'(req_grant), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
